mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Purpose  : Shared types and constants for the video/system RAM arbiter.
// Revision : 1.0
// ============================================================================
package mem_bus_pkg;

    localparam int C_DEFAULT_AW = 16;
    localparam int C_DEFAULT_DW = 16;
    localparam int C_STALL_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ACK     = 3'd4
    } cpu_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one synchronous RAM port between the VGA fetch engine
//            (absolute priority) and the CPU, using the VGA look-ahead hint.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW = C_DEFAULT_AW,
    parameter int DW = C_DEFAULT_DW
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [AW-1:0]        i_vga_addr,
    input  logic                 i_vga_cs,
    input  logic                 i_vga_access,
    output logic [DW-1:0]        o_vga_dat,
    input  logic [AW-1:0]        i_cpu_addr,
    input  logic [DW-1:0]        i_cpu_dat,
    input  logic                 i_cpu_cs,
    input  logic                 i_cpu_we,
    output logic [DW-1:0]        o_cpu_dat,
    output logic                 o_cpu_ack,
    output logic [AW-1:0]        o_ram_addr,
    output logic [DW-1:0]        o_ram_dat,
    output logic                 o_ram_cs,
    output logic                 o_ram_we,
    input  logic [DW-1:0]        i_ram_dat,
    output logic                 o_collision,
    output logic [C_STALL_W-1:0] o_stall_max
);

    cpu_state_t            r_state;
    cpu_state_t            w_state_nxt;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_dat;
    logic                  r_we;
    logic [DW-1:0]         r_cpu_dat;
    logic                  r_collision;
    logic [C_STALL_W-1:0]  r_stall;
    logic [C_STALL_W-1:0]  r_stall_max;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_dat       <= '0;
            r_we        <= 1'b0;
            r_cpu_dat   <= '0;
            r_collision <= 1'b0;
            r_stall     <= '0;
            r_stall_max <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && i_cpu_cs) begin
                r_addr <= i_cpu_addr;
                r_dat  <= i_cpu_dat;
                r_we   <= i_cpu_we;
            end
            if (r_state == ST_WAIT && r_stall != '1) begin
                r_stall <= r_stall + 1'b1;
            end
            // VGA grabbed the port without announcing it first
            if (r_state == ST_ISSUE && i_vga_cs) begin
                r_collision <= 1'b1;
            end
            if (r_state == ST_CAPTURE) begin
                if (!r_we) begin
                    r_cpu_dat <= i_ram_dat;
                end
                if (r_stall > r_stall_max) begin
                    r_stall_max <= r_stall;
                end
                r_stall <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_cpu_cs) begin
                    w_state_nxt = i_vga_access ? ST_WAIT : ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (!i_vga_access) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE:   w_state_nxt = i_vga_cs ? ST_WAIT : ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_ACK;
            ST_ACK:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ram_addr = '0;
        o_ram_dat  = '0;
        o_ram_we   = 1'b0;
        o_ram_cs   = 1'b0;
        if (i_vga_cs) begin
            o_ram_addr = i_vga_addr;
            o_ram_cs   = 1'b1;
        end else if (r_state == ST_ISSUE) begin
            o_ram_addr = r_addr;
            o_ram_dat  = r_dat;
            o_ram_we   = r_we;
            o_ram_cs   = 1'b1;
        end
    end

    assign o_vga_dat   = i_ram_dat;
    assign o_cpu_dat   = r_cpu_dat;
    assign o_cpu_ack   = (r_state == ST_ACK);
    assign o_collision = r_collision;
    assign o_stall_max = r_stall_max;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter with a RAM model and a
//            transaction-level reference for CPU timing, data and statistics.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [AW-1:0] i_vga_addr = '0;
    logic          i_vga_cs = 1'b0;
    logic          i_vga_access = 1'b0;
    logic [DW-1:0] o_vga_dat;
    logic [AW-1:0] i_cpu_addr = '0;
    logic [DW-1:0] i_cpu_dat = '0;
    logic          i_cpu_cs = 1'b0;
    logic          i_cpu_we = 1'b0;
    logic [DW-1:0] o_cpu_dat;
    logic          o_cpu_ack;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_dat;
    logic          o_ram_cs;
    logic          o_ram_we;
    logic [DW-1:0] i_ram_dat;
    logic          o_collision;
    logic [7:0]    o_stall_max;

    mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_vga_addr   (i_vga_addr),
        .i_vga_cs     (i_vga_cs),
        .i_vga_access (i_vga_access),
        .o_vga_dat    (o_vga_dat),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_dat    (i_cpu_dat),
        .i_cpu_cs     (i_cpu_cs),
        .i_cpu_we     (i_cpu_we),
        .o_cpu_dat    (o_cpu_dat),
        .o_cpu_ack    (o_cpu_ack),
        .o_ram_addr   (o_ram_addr),
        .o_ram_dat    (o_ram_dat),
        .o_ram_cs     (o_ram_cs),
        .o_ram_we     (o_ram_we),
        .i_ram_dat    (i_ram_dat),
        .o_collision  (o_collision),
        .o_stall_max  (o_stall_max)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data appears one cycle after the address
    logic [DW-1:0] ram       [0:65535];
    logic [DW-1:0] model_mem [0:65535];
    logic [DW-1:0] r_ram_q = '0;

    always @(posedge clk) begin
        if (o_ram_cs && o_ram_we) ram[o_ram_addr] <= o_ram_dat;
        r_ram_q <= ram[o_ram_addr];
    end
    assign i_ram_dat = r_ram_q;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_cpu_dat   = '0;
    logic [7:0]    exp_stall_max = '0;
    logic          exp_collision = 1'b0;

    bit            acc   [0:399];
    bit            vcs   [0:399];
    logic [AW-1:0] vaddr [0:399];

    // mode: 0 random VGA traffic, 1 VGA idle, 2 unannounced VGA cs at issue,
    //       3 long VGA burst, 4 three announced fetches at request time
    task automatic run_txn(input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] dat, input int mode);
        int issue, ack_c, stalls, nxt, coll_t;
        logic [DW-1:0]   exp_rd;
        logic [AW+DW+1:0] exp_bus;
        logic [AW+DW+1:0] got_bus;
        for (int i = 0; i < 400; i++) begin
            acc[i]   = 1'b0;
            vcs[i]   = 1'b0;
            vaddr[i] = AW'($urandom);
        end
        case (mode)
            0: for (int i = 0; i < 8; i++) acc[i] = 1'($urandom_range(0, 1));
            3: for (int i = 0; i < 300; i++) acc[i] = 1'b1;
            4: for (int i = 0; i < 3; i++) acc[i] = 1'b1;
            default: ;
        endcase
        for (int i = 1; i < 400; i++) vcs[i] = acc[i-1];

        // CPU may issue only in a cycle whose preceding access hint was low
        issue = 1;
        while (acc[issue-1]) issue++;
        stalls = issue - 1;
        coll_t = -1;
        if (mode == 2) begin
            vcs[issue] = 1'b1;
            coll_t = issue;
            nxt = issue + 2;
            while (acc[nxt-1]) nxt++;
            stalls = stalls + (nxt - issue - 1);
            issue = nxt;
        end
        ack_c = issue + 2;
        if (stalls > 255) stalls = 255;
        exp_rd = model_mem[addr];

        for (int t = 0; t <= ack_c; t++) begin
            @(posedge clk);
            #1;
            i_cpu_cs     = 1'b1;
            i_cpu_we     = we;
            i_cpu_addr   = addr;
            i_cpu_dat    = dat;
            i_vga_access = acc[t];
            i_vga_cs     = vcs[t];
            i_vga_addr   = vcs[t] ? vaddr[t] : AW'($urandom);
            @(negedge clk);

            n_checks++;
            if (o_cpu_ack !== (t == ack_c)) begin
                n_fail++;
                $display("FAIL ack t=%0d mode=%0d: got %b expected %b", t, mode, o_cpu_ack, (t == ack_c));
            end

            if (vcs[t]) begin
                exp_bus = {1'b1, 1'b0, vaddr[t], DW'(0)};
                got_bus = {o_ram_cs, o_ram_we, o_ram_addr, DW'(0)};
            end else if (t == issue) begin
                exp_bus = {1'b1, we, addr, dat};
                got_bus = {o_ram_cs, o_ram_we, o_ram_addr, o_ram_dat};
            end else begin
                exp_bus = '0;
                got_bus = {o_ram_cs, o_ram_we, o_ram_addr, o_ram_dat};
            end
            n_checks++;
            if (got_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL ram_port t=%0d mode=%0d: got %h expected %h", t, mode, got_bus, exp_bus);
            end

            if (t >= 1 && vcs[t-1]) begin
                n_checks++;
                if (o_vga_dat !== model_mem[vaddr[t-1]]) begin
                    n_fail++;
                    $display("FAIL vga_dat t=%0d: got %h expected %h", t, o_vga_dat, model_mem[vaddr[t-1]]);
                end
            end

            if (coll_t >= 0 && t > coll_t) exp_collision = 1'b1;
            n_checks++;
            if (o_collision !== exp_collision) begin
                n_fail++;
                $display("FAIL collision t=%0d: got %b expected %b", t, o_collision, exp_collision);
            end

            if (t == issue && we) model_mem[addr] = dat;

            if (t == ack_c) begin
                if (!we) exp_cpu_dat = exp_rd;
                if (8'(stalls) > exp_stall_max) exp_stall_max = 8'(stalls);
                n_checks++;
                if (o_cpu_dat !== exp_cpu_dat) begin
                    n_fail++;
                    $display("FAIL cpu_dat addr=%h: got %h expected %h", addr, o_cpu_dat, exp_cpu_dat);
                end
                n_checks++;
                if (o_stall_max !== exp_stall_max) begin
                    n_fail++;
                    $display("FAIL stall_max: got %0d expected %0d", o_stall_max, exp_stall_max);
                end
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        i_cpu_cs     = 1'b0;
        i_vga_cs     = 1'b0;
        i_vga_access = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({o_cpu_ack, o_cpu_dat, o_collision, o_stall_max} !== '0) begin
            n_fail++;
            $display("FAIL %s regs: got ack=%b dat=%h coll=%b smax=%0d expected all 0",
                     tag, o_cpu_ack, o_cpu_dat, o_collision, o_stall_max);
        end
        n_checks++;
        if ({o_ram_cs, o_ram_we, o_ram_addr, o_ram_dat} !== '0) begin
            n_fail++;
            $display("FAIL %s ram: got cs=%b we=%b addr=%h dat=%h expected all 0",
                     tag, o_ram_cs, o_ram_we, o_ram_addr, o_ram_dat);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        i_reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");
    endtask

    task automatic test_read_idle();
        run_txn(1'b0, 16'h1234, 16'h0000, 1);
        n_checks++;
        if (o_cpu_dat !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL read_beef: got %h expected beef", o_cpu_dat);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 16'h2000, 16'hA55A, 1);
        run_txn(1'b0, 16'h2000, 16'h0000, 1);
        n_checks++;
        if (o_cpu_dat !== 16'hA55A) begin
            n_fail++;
            $display("FAIL write_read: got %h expected a55a", o_cpu_dat);
        end
    endtask

    task automatic test_vga_contention();
        idle_cycle();
        run_txn(1'b0, 16'h1234, 16'h0000, 4);
        n_checks++;
        if (o_stall_max !== 8'd3) begin
            n_fail++;
            $display("FAIL contention_stall: got %0d expected 3", o_stall_max);
        end
    endtask

    task automatic test_collision();
        idle_cycle();
        run_txn(1'b0, 16'h2000, 16'h0000, 2);
        idle_cycle();
        @(negedge clk);
        n_checks++;
        if (o_collision !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_sticky: got %b expected 1", o_collision);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        i_cpu_cs = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        #1;
        check_all_zero("reset_mid");
        i_cpu_cs = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        exp_cpu_dat = '0; exp_stall_max = '0; exp_collision = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_cpu_ack !== 1'b0 || o_ram_cs !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset k=%0d: got ack=%b ram_cs=%b expected 0 0", k, o_cpu_ack, o_ram_cs);
            end
        end
        run_txn(1'b0, 16'h1234, 16'h0000, 1);
    endtask

    task automatic test_held_cs();
        logic [AW-1:0] a;
        a = 16'h3000 + AW'($urandom_range(0, 3));
        exp_cpu_dat = model_mem[a];
        idle_cycle();
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            i_cpu_cs = (t <= 7); i_cpu_we = 1'b0; i_cpu_addr = a;
            i_vga_cs = 1'b0; i_vga_access = 1'b0;
            @(negedge clk);
            n_checks++;
            if (o_cpu_ack !== (t == 3 || t == 7)) begin
                n_fail++;
                $display("FAIL held_ack t=%0d: got %b expected %b", t, o_cpu_ack, (t == 3 || t == 7));
            end
            if (t == 3 || t == 7) begin
                n_checks++;
                if (o_cpu_dat !== exp_cpu_dat) begin
                    n_fail++;
                    $display("FAIL held_dat t=%0d: got %h expected %h", t, o_cpu_dat, exp_cpu_dat);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 1) idle_cycle();
            run_txn(1'($urandom_range(0, 1)), 16'h3000 + AW'($urandom_range(0, 3)),
                    DW'($urandom), 0);
        end
    endtask

    task automatic test_stall_saturation();
        idle_cycle();
        run_txn(1'b0, 16'h2000, 16'h0000, 3);
        n_checks++;
        if (o_stall_max !== 8'd255) begin
            n_fail++;
            $display("FAIL stall_saturate: got %0d expected 255", o_stall_max);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]       = DW'($urandom);
            model_mem[i] = ram[i];
        end
        ram[16'h1234]       = 16'hBEEF;
        model_mem[16'h1234] = 16'hBEEF;

        test_reset();
        test_read_idle();
        test_back_to_back();
        test_vga_contention();
        test_collision();
        test_reset_mid();
        test_held_cs();
        test_random();
        test_stall_saturation();
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
